// File: rtl/ram_dma.sv
// Block-transfer engine in front of a 256x8 ram. It shares the ram port between the CPU and a copy/fill sequencer.
// Active-low strobes follow the usual convention: 0 = asserted, 1 = released.
module ram_dma #(
    parameter int BYTES = 256
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] cpu_addr_i,
    input  logic [7:0] cpu_d_in_i,
    input  logic       cpu_rd_n_i,
    input  logic       cpu_wr_n_i,
    output logic [7:0] cpu_d_out_o,
    output logic       cpu_wait_n_o,
    input  logic       start_n_i,
    input  logic       mode_i,
    input  logic [7:0] src_i,
    input  logic [7:0] dst_i,
    input  logic [7:0] len_i,
    input  logic [7:0] fill_val_i,
    output logic       busy_o,
    output logic       done_o,
    output logic [7:0] ram_addr_o,
    output logic [7:0] ram_d_in_o,
    output logic       ram_rd_n_o,
    output logic       ram_wr_n_o,
    input  logic [7:0] ram_d_out_i
);

    // state | meaning
    // IDLE  | CPU owns the ram, waiting for start_n_i
    // RD    | engine reads src_q into buf_q
    // WR    | engine writes buf_q to dst_q
    // FILL  | engine writes fill_q to dst_q
    // DONE  | one-cycle done pulse, CPU already owns the ram
    typedef enum logic [2:0] {IDLE, RD, WR, FILL, DONE} state_t;

    localparam int AW = $clog2(BYTES);

    state_t        state_q, state_d;
    logic [AW-1:0] src_q, src_d;
    logic [AW-1:0] dst_q, dst_d;
    logic [7:0]    cnt_q, cnt_d;
    logic [7:0]    buf_q, buf_d;
    logic [7:0]    fill_q, fill_d;

    assign cpu_d_out_o = ram_d_out_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            src_q   <= '0;
            dst_q   <= '0;
            cnt_q   <= '0;
            buf_q   <= '0;
            fill_q  <= '0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            cnt_q   <= cnt_d;
            buf_q   <= buf_d;
            fill_q  <= fill_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        src_d        = src_q;
        dst_d        = dst_q;
        cnt_d        = cnt_q;
        buf_d        = buf_q;
        fill_d       = fill_q;
        ram_addr_o   = cpu_addr_i;
        ram_d_in_o   = cpu_d_in_i;
        ram_rd_n_o   = cpu_rd_n_i;
        ram_wr_n_o   = cpu_wr_n_i;
        cpu_wait_n_o = 1'b1;
        busy_o       = 1'b0;
        done_o       = 1'b0;

        case (state_q)
            IDLE: begin
                if (!start_n_i) begin
                    src_d  = src_i;
                    dst_d  = dst_i;
                    cnt_d  = len_i;
                    fill_d = fill_val_i;
                    if (len_i == 8'd0)
                        state_d = DONE;
                    else if (mode_i)
                        state_d = FILL;
                    else
                        state_d = RD;
                end
            end
            RD: begin
                ram_addr_o   = src_q;
                ram_rd_n_o   = 1'b0;
                ram_wr_n_o   = 1'b1;
                cpu_wait_n_o = 1'b0;
                busy_o       = 1'b1;
                buf_d        = ram_d_out_i;
                state_d      = WR;
            end
            WR: begin
                ram_addr_o   = dst_q;
                ram_d_in_o   = buf_q;
                ram_rd_n_o   = 1'b1;
                ram_wr_n_o   = 1'b0;
                cpu_wait_n_o = 1'b0;
                busy_o       = 1'b1;
                src_d        = src_q + 1'b1;
                dst_d        = dst_q + 1'b1;
                cnt_d        = cnt_q - 8'd1;
                state_d      = (cnt_q == 8'd1) ? DONE : RD;
            end
            FILL: begin
                ram_addr_o   = dst_q;
                ram_d_in_o   = fill_q;
                ram_rd_n_o   = 1'b1;
                ram_wr_n_o   = 1'b0;
                cpu_wait_n_o = 1'b0;
                busy_o       = 1'b1;
                dst_d        = dst_q + 1'b1;
                cnt_d        = cnt_q - 8'd1;
                state_d      = (cnt_q == 8'd1) ? DONE : FILL;
            end
            DONE: begin
                done_o  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Keep the ram quiet while reset is held, whatever the CPU is driving.
        if (!rst_n) begin
            ram_rd_n_o = 1'b1;
            ram_wr_n_o = 1'b1;
        end
    end

endmodule

// File: tb/tb_ram_dma.sv
// Bench for ram_dma. It uses a behavioural 256x8 ram, a table of transfer commands and a reference memory.
// The expected ram bytes go into a scoreboard queue when a command is issued and are checked after the transfer completes.
module tb_ram_dma;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] cpu_addr, cpu_d_in, cpu_d_out;
    logic       cpu_rd_n, cpu_wr_n, cpu_wait_n;
    logic       start_n, mode;
    logic [7:0] src, dst, len, fill_val;
    logic       busy, done;
    logic [7:0] ram_addr, ram_d_in, ram_d_out;
    logic       ram_rd_n, ram_wr_n;

    logic [7:0] mem [256];
    logic [7:0] ref_mem [256];
    logic       mem_init;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [7:0] addr;
        logic [7:0] data;
    } exp_t;
    exp_t sbq[$];

    typedef struct {
        logic       mode;
        logic [7:0] src;
        logic [7:0] dst;
        logic [7:0] len;
        logic [7:0] fill;
        int         exp_busy;
        int         exp_done;
        string      name;
    } vec_t;
    vec_t vecs[6];

    always #5 clk = ~clk;

    ram_dma dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cpu_addr_i   (cpu_addr),
        .cpu_d_in_i   (cpu_d_in),
        .cpu_rd_n_i   (cpu_rd_n),
        .cpu_wr_n_i   (cpu_wr_n),
        .cpu_d_out_o  (cpu_d_out),
        .cpu_wait_n_o (cpu_wait_n),
        .start_n_i    (start_n),
        .mode_i       (mode),
        .src_i        (src),
        .dst_i        (dst),
        .len_i        (len),
        .fill_val_i   (fill_val),
        .busy_o       (busy),
        .done_o       (done),
        .ram_addr_o   (ram_addr),
        .ram_d_in_o   (ram_d_in),
        .ram_rd_n_o   (ram_rd_n),
        .ram_wr_n_o   (ram_wr_n),
        .ram_d_out_i  (ram_d_out)
    );

    // behavioural ram: combinational read, write on posedge
    assign ram_d_out = mem[ram_addr];
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 256; i++) mem[i] <= 8'(i * 7 + 3);
        end else if (!ram_wr_n) begin
            mem[ram_addr] <= ram_d_in;
        end
    end

    task automatic check(input string nm, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, exp, exp);
        end
    endtask

    task automatic check_mem(input string nm);
        int bad = 0;
        int first = -1;
        for (int i = 0; i < 256; i++) begin
            if (mem[i] !== ref_mem[i]) begin
                bad++;
                if (first < 0) first = i;
            end
        end
        tests++;
        if (bad != 0) begin
            fails++;
            $display("FAIL %s mem_all: %0d bytes differ, first at 0x%0h got 0x%0h expected 0x%0h",
                     nm, bad, first, mem[first], ref_mem[first]);
        end
    endtask

    task automatic cpu_write(input logic [7:0] a, input logic [7:0] d);
        @(negedge clk);
        cpu_addr = a;
        cpu_d_in = d;
        cpu_rd_n = 1'b1;
        cpu_wr_n = 1'b0;
        @(posedge clk);
        #1;
        cpu_wr_n = 1'b1;
        cpu_rd_n = 1'b0;
        ref_mem[a] = d;
    endtask

    task automatic run_cmd(input logic md, input logic [7:0] s, input logic [7:0] d,
                           input logic [7:0] l, input logic [7:0] f,
                           input int eb, input int ed, input string nm, input bit mid);
        int busy_c = 0, wait_c = 0, wr_c = 0, done_c = 0, both_c = 0, done_at = -1;
        logic [7:0] a;
        exp_t e;
        for (int i = 0; i < int'(l); i++) begin
            a = d + 8'(i);
            ref_mem[a] = md ? f : ref_mem[8'(s + 8'(i))];
            sbq.push_back(exp_t'{a, ref_mem[a]});
        end
        @(negedge clk);
        start_n  = 1'b0;
        mode     = md;
        src      = s;
        dst      = d;
        len      = l;
        fill_val = f;
        cpu_addr = 8'hCC;
        cpu_rd_n = 1'b0;
        cpu_wr_n = 1'b1;
        @(posedge clk);
        #1;
        start_n = 1'b1;
        for (int c = 1; c <= 2 * int'(l) + 6; c++) begin
            @(negedge clk);
            if (busy) busy_c++;
            if (!cpu_wait_n) wait_c++;
            if (!ram_wr_n) wr_c++;
            if (!ram_wr_n && !ram_rd_n) both_c++;
            if (done) begin
                done_c++;
                if (done_at < 0) done_at = c;
            end
            if (mid && c == 2) begin
                start_n  = 1'b0;
                mode     = 1'b1;
                src      = 8'h60;
                dst      = 8'h70;
                len      = 8'd2;
                fill_val = 8'hEE;
            end
            if (mid && c == 3) start_n = 1'b1;
        end
        check({nm, " busy_cycles"}, busy_c, eb);
        check({nm, " wait_cycles"}, wait_c, eb);
        check({nm, " done_cycle"}, done_at, ed);
        check({nm, " done_pulses"}, done_c, 1);
        check({nm, " ram_writes"}, wr_c, int'(l));
        check({nm, " rd_wr_both_low"}, both_c, 0);
        while (sbq.size() > 0) begin
            e = sbq.pop_front();
            check($sformatf("%s ram[%02h]", nm, e.addr), int'(mem[e.addr]), int'(e.data));
        end
        check_mem(nm);
    endtask

    initial begin
        int done_c;
        vecs[0] = '{1'b0, 8'h10, 8'h20, 8'd4,  8'h00, 8,  9,  "copy4"};
        vecs[1] = '{1'b1, 8'h00, 8'hFE, 8'd4,  8'h2E, 4,  5,  "fill_wrap"};
        vecs[2] = '{1'b0, 8'h40, 8'h50, 8'd0,  8'h00, 0,  1,  "len0"};
        vecs[3] = '{1'b0, 8'h30, 8'h31, 8'd3,  8'h00, 6,  7,  "overlap"};
        vecs[4] = '{1'b1, 8'h00, 8'h80, 8'd1,  8'h9C, 1,  2,  "fill1"};
        vecs[5] = '{1'b0, 8'hF0, 8'h08, 8'd20, 8'h00, 40, 41, "copy_srcwrap"};

        rst_n    = 1'b0;
        mem_init = 1'b1;
        start_n  = 1'b1;
        mode     = 1'b0;
        src      = 8'h00;
        dst      = 8'h00;
        len      = 8'h00;
        fill_val = 8'h00;
        cpu_addr = 8'h05;
        cpu_d_in = 8'h00;
        cpu_rd_n = 1'b0;
        cpu_wr_n = 1'b0;
        for (int i = 0; i < 256; i++) ref_mem[i] = 8'(i * 7 + 3);
        repeat (2) @(posedge clk);
        #1;
        mem_init = 1'b0;
        check("rst busy", busy, 0);
        check("rst done", done, 0);
        check("rst cpu_wait_n", cpu_wait_n, 1);
        check("rst ram_rd_n", ram_rd_n, 1);
        check("rst ram_wr_n", ram_wr_n, 1);
        @(negedge clk);
        cpu_wr_n = 1'b1;
        rst_n    = 1'b1;
        @(negedge clk);

        cpu_write(8'h10, 8'h41);
        cpu_write(8'h11, 8'h42);
        cpu_write(8'h12, 8'h43);
        cpu_write(8'h13, 8'h44);
        cpu_write(8'h30, 8'h55);
        cpu_addr = 8'h12;
        #1;
        check("passthru cpu_d_out", cpu_d_out, 8'h43);
        check("passthru ram_rd_n", ram_rd_n, 0);
        check_mem("cpu_writes");

        for (int v = 0; v < 6; v++)
            run_cmd(vecs[v].mode, vecs[v].src, vecs[v].dst, vecs[v].len, vecs[v].fill,
                    vecs[v].exp_busy, vecs[v].exp_done, vecs[v].name, 1'b0);

        // second start_n pulse while a copy is in flight must be ignored
        run_cmd(1'b0, 8'h40, 8'h50, 8'd3, 8'h00, 6, 7, "restart_ignored", 1'b1);

        // reset during the third write of a six-byte fill
        ref_mem[8'h90] = 8'h77;
        ref_mem[8'h91] = 8'h77;
        @(negedge clk);
        start_n  = 1'b0;
        mode     = 1'b1;
        dst      = 8'h90;
        len      = 8'd6;
        fill_val = 8'h77;
        cpu_addr = 8'h90;
        cpu_rd_n = 1'b0;
        @(posedge clk);
        #1;
        start_n = 1'b1;
        done_c  = 0;
        repeat (3) begin
            @(negedge clk);
            if (done) done_c++;
        end
        check("abort busy_before", busy, 1);
        rst_n = 1'b0;
        #1;
        check("abort busy", busy, 0);
        check("abort cpu_wait_n", cpu_wait_n, 1);
        check("abort ram_wr_n", ram_wr_n, 1);
        check("abort ram_rd_n", ram_rd_n, 1);
        repeat (3) begin
            @(negedge clk);
            if (done) done_c++;
        end
        rst_n = 1'b1;
        #1;
        check("abort read ram_addr", ram_addr, 8'h90);
        check("abort read ram_rd_n", ram_rd_n, 0);
        check("abort read cpu_d_out", cpu_d_out, 8'h77);
        repeat (4) begin
            @(negedge clk);
            if (done || busy) done_c++;
        end
        check("abort no_done", done_c, 0);
        check_mem("abort");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
